// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary -> packed BCD, one shift per clock.
// Optional macro BCD_AUTO_START_EN: convert automatically whenever binary_in changes (start ignored).
module bin_to_bcd_seq #(
  parameter int BIN_W = 8,
  parameter int BCD_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] binary_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out,
  output logic             overflow
);

  // Decimal digit count of the largest BIN_W-bit value.
  function automatic int calc_nd(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v > 0) begin
        v = v / 10;
        n++;
      end
    end
    return (n == 0) ? 1 : n;
  endfunction

  localparam int ND    = calc_nd(BIN_W);
  localparam int BCDS  = 4 * ND;
  localparam int SW    = BCDS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    adj;
  logic [BCDS-1:0]  bcd_sec;
  logic [BCD_W-1:0] trunc;
  logic             drop;
  logic             launch;

`ifdef BCD_AUTO_START_EN
  logic [BIN_W-1:0] last_q, last_d;
  assign launch = (binary_in != last_q);
`else
  assign launch = start;
`endif

  assign bcd_sec = scratch_q[SW-1:BIN_W];

  generate
    if (BCD_W < BCDS) begin : g_trunc
      assign trunc = bcd_sec[BCD_W-1:0];
      assign drop  = |bcd_sec[BCDS-1:BCD_W];
    end else begin : g_fit
      assign trunc = BCD_W'(bcd_sec);
      assign drop  = 1'b0;
    end
  endgenerate

  // Add-3 correction on every BCD digit before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < ND; i++) begin
      if (scratch_q[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = scratch_q[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef BCD_AUTO_START_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          scratch_d = {{BCDS{1'b0}}, binary_in};
          cnt_d     = '0;
          state_d   = S_SHIFT;
`ifdef BCD_AUTO_START_EN
          last_d    = binary_in;
`endif
        end
      end
      S_SHIFT: begin
        scratch_d = {adj[SW-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = trunc;
        ovf_d   = drop;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BCD_AUTO_START_EN
      last_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef BCD_AUTO_START_EN
      last_q    <= last_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default instance plus a BCD_W=8 instance to exercise truncation.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] binary_in = '0;
  logic       busy, done, overflow;
  logic [9:0] bcd_out;
  logic       busy8, done8, overflow8;
  logic [7:0] bcd_out8;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [10:0] exp_q[$];
  logic [8:0]  exp8_q[$];

  bin_to_bcd_seq #(.BIN_W(8), .BCD_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .binary_in(binary_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(8), .BCD_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .binary_in(binary_in),
    .busy(busy8), .done(done8), .bcd_out(bcd_out8), .overflow(overflow8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by arithmetic, packed 4 bits each, then cut to w bits.
  function automatic logic [32:0] ref_bcd(input int v, input int w);
    logic [31:0] full;
    int x;
    full = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      full[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {((full >> w) != 0) ? 1'b1 : 1'b0, full & ((32'd1 << w) - 1)};
  endfunction

  function automatic logic digits_ok(input logic [9:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
  endfunction

  task automatic push_exp(input int v);
    logic [32:0] r;
    r = ref_bcd(v, 10);
    exp_q.push_back({r[32], r[9:0]});
    r = ref_bcd(v, 8);
    exp8_q.push_back({r[32], r[7:0]});
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("done_single", 32'(done_prev), 0);
        check("digit_range", 32'(digits_ok(bcd_out)), 1);
        if (exp_q.size() == 0) check("unexpected_done", 32'(done), 0);
        else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e[9:0]));
          check("overflow", 32'(overflow), 32'(e[10]));
        end
      end
      if (done8) begin
        if (exp8_q.size() == 0) check("unexpected_done8", 32'(done8), 0);
        else begin
          logic [8:0] e8;
          e8 = exp8_q.pop_front();
          check("bcd_out8", 32'(bcd_out8), 32'(e8[7:0]));
          check("overflow8", 32'(overflow8), 32'(e8[8]));
        end
      end
    end
    done_prev = done;
  end

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) return;
      if (busy) busy_cnt++;
    end
    check("done_timeout", 32'(done), 1);
  endtask

  task automatic run_conv(input int v);
    int lat, bc;
    binary_in = 8'(v);
    start = 1'b1;
    push_exp(v);
    @(posedge clk); #1;
    start = 1'b0;
    binary_in = 8'($urandom);
    check("busy_after_accept", 32'(busy), 1);
    wait_done(lat, bc);
    check("latency", lat, 9);
    check("busy_cycles", bc, 8);
    check("busy_at_done", 32'(busy), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, bc;
    rst = 1'b1;
    idle(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bcd", 32'(bcd_out), 0);
    check("rst_ovf", 32'(overflow8), 0);
    rst = 1'b0;
    idle(5);
    check("idle_no_done", done_cnt, 0);

`ifdef BCD_AUTO_START_EN
    idle(10);
    check("auto_no_done", done_cnt, 0);
    binary_in = 8'd42;
    push_exp(42);
    wait_done(lat, bc);
    idle(15);
    check("auto_one_done", done_cnt, 1);
    for (int k = 0; k < 10; k++) begin
      int v;
      v = (int'(binary_in) + 1 + $urandom_range(0, 253)) % 256;
      binary_in = 8'(v);
      push_exp(v);
      wait_done(lat, bc);
      check("auto_latency", lat, 10);
      idle(2);
    end
`else
    run_conv(255);
    for (int v = 0; v < 256; v++) run_conv(v);
    for (int k = 0; k < 40; k++) begin
      idle($urandom_range(0, 3));
      run_conv($urandom_range(0, 255));
    end

    // start held high, input changed mid-conversion
    binary_in = 8'd37;
    start = 1'b1;
    push_exp(37);
    push_exp(200);
    @(posedge clk); #1;
    idle(3);
    binary_in = 8'd200;
    wait_done(lat, bc);
    @(posedge clk); #1;
    check("b2b_accept", 32'(busy), 1);
    start = 1'b0;
    wait_done(lat, bc);
    check("b2b_latency", lat, 9);

    // reset on the 4th shift cycle of 128
    binary_in = 8'd128;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_bcd", 32'(bcd_out), 0);
    check("abort_ovf8", 32'(overflow8), 0);
    rst = 1'b0;
    idle(2);
    run_conv(128);
    run_conv(200);
    run_conv(99);
`endif
    idle(12);
    check("queue_drained", exp_q.size() + exp8_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
